// File: rtl/dma_ddr_rsp_merge_if.sv
// -----------------------------------------------------------------------------
// dma_ddr_rsp_merge_if
//   Merged response port between the DDR response merge unit and the DMA
//   engine. Carries the R channel (valid/last/payload/ready) and the
//   B channel (valid/payload/ready). Payloads are opaque.
//
//   modport master : response source (the merge unit) - drives valid/payload
//   modport slave  : response sink (DMA engine)       - drives ready
// -----------------------------------------------------------------------------
interface dma_ddr_rsp_merge_if #(
  parameter int R_W = 512 + 16,
  parameter int B_W = 16
);
  logic           rvalid;
  logic           rlast;
  logic [R_W-1:0] r;
  logic           rready;
  logic           bvalid;
  logic [B_W-1:0] b;
  logic           bready;

  modport master (output rvalid, rlast, r, bvalid, b, input rready, bready);
  modport slave  (input rvalid, rlast, r, bvalid, b, output rready, bready);
endinterface

// File: rtl/dma_ddr_rsp_merge.sv
// -----------------------------------------------------------------------------
// dma_ddr_rsp_merge
//   Returns R and B responses from N local-memory banks to one DMA port in
//   request order. Every accepted AR/AW pushes its bank number into a read or
//   write order FIFO; only the bank at the head of the FIFO is connected to the
//   merged port. R pops on the rlast handshake, B pops on every handshake.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   ar_fire/ar_bank/ar_ok   read request accepted / its bank / tracker has room
//   aw_fire/aw_bank/aw_ok   write request accepted / its bank / tracker has room
//   bank_r*                 per-bank R channel (valid, last, payload, ready)
//   bank_b*                 per-bank B channel (valid, payload, ready)
//   m                       merged R/B port toward the DMA engine (master side)
//   rd/wr_outstanding       order FIFO occupancy
//   err_overflow            sticky: fire seen while the tracker was full
//   err_stray               sticky: valid from a non-head bank or while empty
//
// Build option
//   DMA_RSP_MERGE_OUTPUT_REG_EN : when defined, each merged output is fed from
//   a 2-entry skid buffer (outputs from flops, +1 cycle latency, full rate).
// -----------------------------------------------------------------------------
module dma_ddr_rsp_merge #(
  parameter  int NUM_LOCAL_MEM_BANKS = 2,
  parameter  int R_W                 = 512 + 16,
  parameter  int B_W                 = 16,
  parameter  int MAX_OUTSTANDING     = 16,
  localparam int BANK_W = (NUM_LOCAL_MEM_BANKS > 1) ? $clog2(NUM_LOCAL_MEM_BANKS) : 1,
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               ar_fire,
  input  logic [BANK_W-1:0]                  ar_bank,
  output logic                               ar_ok,
  input  logic                               aw_fire,
  input  logic [BANK_W-1:0]                  aw_bank,
  output logic                               aw_ok,
  input  logic [NUM_LOCAL_MEM_BANKS-1:0]     bank_rvalid,
  input  logic [NUM_LOCAL_MEM_BANKS-1:0]     bank_rlast,
  input  logic [NUM_LOCAL_MEM_BANKS*R_W-1:0] bank_r,
  output logic [NUM_LOCAL_MEM_BANKS-1:0]     bank_rready,
  input  logic [NUM_LOCAL_MEM_BANKS-1:0]     bank_bvalid,
  input  logic [NUM_LOCAL_MEM_BANKS*B_W-1:0] bank_b,
  output logic [NUM_LOCAL_MEM_BANKS-1:0]     bank_bready,
  dma_ddr_rsp_merge_if.master                m,
  output logic [CNT_W-1:0]                   rd_outstanding,
  output logic [CNT_W-1:0]                   wr_outstanding,
  output logic                               err_overflow,
  output logic                               err_stray
);
  localparam int N     = NUM_LOCAL_MEM_BANKS;
  localparam int IDX_W = CNT_W - 1;

  // Index 0 = read tracker, index 1 = write tracker.
  logic [1:0]             trk_fire, trk_pop, trk_ok, trk_empty;
  logic [1:0][BANK_W-1:0] trk_bank, trk_head;
  logic [1:0][CNT_W-1:0]  trk_occ;

  assign trk_fire = {aw_fire, ar_fire};
  assign trk_bank = {aw_bank, ar_bank};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_trk
      logic [BANK_W-1:0] mem_q [MAX_OUTSTANDING];
      logic [CNT_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d, occ;
      logic              push;

      // Pointers carry one extra MSB so occ == MAX_OUTSTANDING is representable;
      // that MSB alone means full because occupancy never exceeds the depth.
      assign occ           = wptr_q - rptr_q;
      assign trk_ok[gi]    = ~occ[CNT_W-1];
      assign trk_empty[gi] = (occ == '0);
      assign trk_occ[gi]   = occ;
      assign trk_head[gi]  = mem_q[rptr_q[IDX_W-1:0]];
      // A fire while full is dropped; a same-cycle pop does not make room.
      assign push          = trk_fire[gi] & trk_ok[gi];

      always_comb begin
        wptr_d = wptr_q + CNT_W'(push);
        rptr_d = rptr_q + CNT_W'(trk_pop[gi]);
      end

      always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q[IDX_W-1:0]] <= trk_bank[gi];
        if (reset) begin
          wptr_q <= '0;
          rptr_q <= '0;
        end else begin
          wptr_q <= wptr_d;
          rptr_q <= rptr_d;
        end
      end
    end
  endgenerate

  assign ar_ok          = trk_ok[0];
  assign aw_ok          = trk_ok[1];
  assign rd_outstanding = trk_occ[0];
  assign wr_outstanding = trk_occ[1];

  // ---------------------------------------------------------------------------
  // Head-bank selection. r_take/b_take is the readiness of whatever sits after
  // the selector (the DMA port directly, or the skid buffer).
  // ---------------------------------------------------------------------------
  logic           sel_rvalid, sel_rlast, r_take, stray_r;
  logic [R_W-1:0] sel_r;
  logic           sel_bvalid, b_take, stray_b;
  logic [B_W-1:0] sel_b;

  always_comb begin
    sel_rvalid  = 1'b0;
    sel_rlast   = 1'b0;
    sel_r       = '0;
    bank_rready = '0;
    stray_r     = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!trk_empty[0] && trk_head[0] == BANK_W'(i)) begin
        sel_rvalid     = bank_rvalid[i];
        sel_rlast      = bank_rlast[i];
        sel_r          = bank_r[i*R_W +: R_W];
        bank_rready[i] = r_take;
      end else if (bank_rvalid[i]) begin
        stray_r = 1'b1;
      end
    end
  end

  always_comb begin
    sel_bvalid  = 1'b0;
    sel_b       = '0;
    bank_bready = '0;
    stray_b     = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!trk_empty[1] && trk_head[1] == BANK_W'(i)) begin
        sel_bvalid     = bank_bvalid[i];
        sel_b          = bank_b[i*B_W +: B_W];
        bank_bready[i] = b_take;
      end else if (bank_bvalid[i]) begin
        stray_b = 1'b1;
      end
    end
  end

  // Reads retire on the last beat only; every B handshake retires a write.
  assign trk_pop = {sel_bvalid & b_take, sel_rvalid & r_take & sel_rlast};

`ifdef DMA_RSP_MERGE_OUTPUT_REG_EN
  // 2-entry skid buffers: accept while not full, so a full-rate stream keeps
  // flowing even though the ready seen by the bank comes from a flop.
  logic [R_W:0]   rsk_mem_q [2];
  logic [1:0]     rsk_cnt_q, rsk_cnt_d;
  logic           rsk_wp_q, rsk_wp_d, rsk_rp_q, rsk_rp_d, rsk_in, rsk_out;
  logic [B_W-1:0] bsk_mem_q [2];
  logic [1:0]     bsk_cnt_q, bsk_cnt_d;
  logic           bsk_wp_q, bsk_wp_d, bsk_rp_q, bsk_rp_d, bsk_in, bsk_out;

  assign r_take          = (rsk_cnt_q != 2'd2);
  assign rsk_in          = sel_rvalid & r_take;
  assign rsk_out         = m.rvalid & m.rready;
  assign m.rvalid        = (rsk_cnt_q != 2'd0);
  assign {m.rlast, m.r}  = rsk_mem_q[rsk_rp_q];

  assign b_take          = (bsk_cnt_q != 2'd2);
  assign bsk_in          = sel_bvalid & b_take;
  assign bsk_out         = m.bvalid & m.bready;
  assign m.bvalid        = (bsk_cnt_q != 2'd0);
  assign m.b             = bsk_mem_q[bsk_rp_q];

  always_comb begin
    rsk_wp_d  = rsk_wp_q ^ rsk_in;
    rsk_rp_d  = rsk_rp_q ^ rsk_out;
    rsk_cnt_d = rsk_cnt_q + {1'b0, rsk_in} - {1'b0, rsk_out};
    bsk_wp_d  = bsk_wp_q ^ bsk_in;
    bsk_rp_d  = bsk_rp_q ^ bsk_out;
    bsk_cnt_d = bsk_cnt_q + {1'b0, bsk_in} - {1'b0, bsk_out};
  end

  always_ff @(posedge clk) begin
    if (rsk_in) rsk_mem_q[rsk_wp_q] <= {sel_rlast, sel_r};
    if (bsk_in) bsk_mem_q[bsk_wp_q] <= sel_b;
    if (reset) begin
      rsk_cnt_q <= '0;
      rsk_wp_q  <= 1'b0;
      rsk_rp_q  <= 1'b0;
      bsk_cnt_q <= '0;
      bsk_wp_q  <= 1'b0;
      bsk_rp_q  <= 1'b0;
    end else begin
      rsk_cnt_q <= rsk_cnt_d;
      rsk_wp_q  <= rsk_wp_d;
      rsk_rp_q  <= rsk_rp_d;
      bsk_cnt_q <= bsk_cnt_d;
      bsk_wp_q  <= bsk_wp_d;
      bsk_rp_q  <= bsk_rp_d;
    end
  end
`else
  // Zero-latency pass-through: head cannot change without a pop, so the
  // payload stays stable while valid is held against a low ready.
  assign r_take   = m.rready;
  assign m.rvalid = sel_rvalid;
  assign m.rlast  = sel_rlast;
  assign m.r      = sel_r;
  assign b_take   = m.bready;
  assign m.bvalid = sel_bvalid;
  assign m.b      = sel_b;
`endif

  // ---------------------------------------------------------------------------
  // Sticky error flags, cleared only by reset.
  // ---------------------------------------------------------------------------
  logic err_overflow_q, err_overflow_d, err_stray_q, err_stray_d;

  always_comb begin
    err_overflow_d = err_overflow_q | (ar_fire & ~trk_ok[0]) | (aw_fire & ~trk_ok[1]);
    err_stray_d    = err_stray_q | stray_r | stray_b;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_overflow_q <= 1'b0;
      err_stray_q    <= 1'b0;
    end else begin
      err_overflow_q <= err_overflow_d;
      err_stray_q    <= err_stray_d;
    end
  end

  assign err_overflow = err_overflow_q;
  assign err_stray    = err_stray_q;
endmodule

// File: tb/tb_dma_ddr_rsp_merge.sv
module tb_dma_ddr_rsp_merge;
  localparam int N      = 2;
  localparam int R_W    = 528;
  localparam int B_W    = 16;
  localparam int MAXO   = 16;
  localparam int BANK_W = 1;
  localparam int CNT_W  = 5;

  typedef struct {
    int bank;
    int len;
    int id;
  } txn_t;

  logic                 clk, reset;
  logic                 ar_fire, aw_fire, ar_ok, aw_ok;
  logic [BANK_W-1:0]    ar_bank, aw_bank;
  logic [N-1:0]         bank_rvalid, bank_rlast, bank_rready;
  logic [N*R_W-1:0]     bank_r;
  logic [N-1:0]         bank_bvalid, bank_bready;
  logic [N*B_W-1:0]     bank_b;
  logic [CNT_W-1:0]     rd_outstanding, wr_outstanding;
  logic                 err_overflow, err_stray;

  int n_cmp = 0;
  int n_bad = 0;

  dma_ddr_rsp_merge_if #(.R_W(R_W), .B_W(B_W)) m_if ();

  dma_ddr_rsp_merge #(
    .NUM_LOCAL_MEM_BANKS(N), .R_W(R_W), .B_W(B_W), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .reset(reset),
    .ar_fire(ar_fire), .ar_bank(ar_bank), .ar_ok(ar_ok),
    .aw_fire(aw_fire), .aw_bank(aw_bank), .aw_ok(aw_ok),
    .bank_rvalid(bank_rvalid), .bank_rlast(bank_rlast), .bank_r(bank_r), .bank_rready(bank_rready),
    .bank_bvalid(bank_bvalid), .bank_b(bank_b), .bank_bready(bank_bready),
    .m(m_if),
    .rd_outstanding(rd_outstanding), .wr_outstanding(wr_outstanding),
    .err_overflow(err_overflow), .err_stray(err_stray)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Unique, recognisable payloads per (transaction, beat).
  function automatic logic [R_W-1:0] rtag(int id, int beat);
    logic [R_W-1:0] v;
    v = '0;
    v[15:0]          = id[15:0];
    v[23:16]         = beat[7:0];
    v[R_W-1 -: 16]   = ~id[15:0];
    return v;
  endfunction

  function automatic logic [B_W-1:0] btag(int id);
    logic [B_W-1:0] v;
    v = id[15:0] * 16'd7 + 16'd3;
    return v ^ 16'hA5A5;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ar_fire = 1'b0; aw_fire = 1'b0; ar_bank = '0; aw_bank = '0;
    bank_rvalid = '0; bank_rlast = '0; bank_r = '0;
    bank_bvalid = '0; bank_b = '0;
    m_if.rready = 1'b0; m_if.bready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    step();
    reset = 1'b1; ar_fire = 1'b1; aw_fire = 1'b1; m_if.rready = 1'b1; m_if.bready = 1'b1;
    step();
    step();
    samp();
    n_cmp++; if (rd_outstanding !== 5'd0) begin n_bad++; $display("FAIL reset_rd_out: got %0d want 0", rd_outstanding); end
    n_cmp++; if (wr_outstanding !== 5'd0) begin n_bad++; $display("FAIL reset_wr_out: got %0d want 0", wr_outstanding); end
    n_cmp++; if (ar_ok !== 1'b1 || aw_ok !== 1'b1) begin n_bad++; $display("FAIL reset_ok: got ar=%b aw=%b want 1 1", ar_ok, aw_ok); end
    n_cmp++; if (m_if.rvalid !== 1'b0 || m_if.bvalid !== 1'b0) begin n_bad++; $display("FAIL reset_mvalid: got r=%b b=%b want 0 0", m_if.rvalid, m_if.bvalid); end
    n_cmp++; if (bank_rready !== 2'b00 || bank_bready !== 2'b00) begin n_bad++; $display("FAIL reset_bank_ready: got r=%b b=%b want 00 00", bank_rready, bank_bready); end
    n_cmp++; if (err_overflow !== 1'b0 || err_stray !== 1'b0) begin n_bad++; $display("FAIL reset_err: got ovf=%b stray=%b want 0 0", err_overflow, err_stray); end
    $display("test_reset done");
  endtask

  // AR bank1 (4 beats) then bank0 (2 beats); bank0 answers early and must wait.
  task automatic test_order_stray();
    do_reset();
    ar_fire = 1'b1; ar_bank = 1'b1;
    step();
    ar_bank = 1'b0;
    step();
    ar_fire = 1'b0;
    bank_rvalid[0] = 1'b1; bank_rlast[0] = 1'b0; bank_r[0 +: R_W] = rtag(20, 0); m_if.rready = 1'b1;
    samp();
    n_cmp++; if (rd_outstanding !== 5'd2) begin n_bad++; $display("FAIL order_occ2: got %0d want 2", rd_outstanding); end
    n_cmp++; if (bank_rready !== 2'b10 || m_if.rvalid !== 1'b0) begin n_bad++; $display("FAIL order_hold_bank0: got rready=%b mvalid=%b want 10 0", bank_rready, m_if.rvalid); end
    step();
    samp();
    n_cmp++; if (err_stray !== 1'b1) begin n_bad++; $display("FAIL order_stray: got %b want 1", err_stray); end
    for (int b = 0; b < 4; b++) begin
      step();
      bank_rvalid[1] = 1'b1; bank_rlast[1] = (b == 3); bank_r[R_W +: R_W] = rtag(10, b);
      samp();
      $display("order bank1 beat %0d rvalid=%b rlast=%b", b, m_if.rvalid, m_if.rlast);
      n_cmp++; if (m_if.rvalid !== 1'b1 || m_if.r !== rtag(10, b) || m_if.rlast !== (b == 3)) begin n_bad++; $display("FAIL order_b1_beat%0d: got v=%b last=%b r=%0h want v=1 last=%b r=%0h", b, m_if.rvalid, m_if.rlast, m_if.r, (b == 3), rtag(10, b)); end
      n_cmp++; if (bank_rready !== 2'b10 || rd_outstanding !== 5'd2) begin n_bad++; $display("FAIL order_b1_ctl%0d: got rready=%b occ=%0d want 10 2", b, bank_rready, rd_outstanding); end
    end
    for (int b = 0; b < 2; b++) begin
      step();
      bank_rvalid[1] = 1'b0; bank_rlast[1] = 1'b0;
      bank_rlast[0] = (b == 1); bank_r[0 +: R_W] = rtag(20, b);
      samp();
      $display("order bank0 beat %0d rvalid=%b rlast=%b", b, m_if.rvalid, m_if.rlast);
      n_cmp++; if (m_if.rvalid !== 1'b1 || m_if.r !== rtag(20, b) || m_if.rlast !== (b == 1)) begin n_bad++; $display("FAIL order_b0_beat%0d: got v=%b last=%b r=%0h want v=1 last=%b r=%0h", b, m_if.rvalid, m_if.rlast, m_if.r, (b == 1), rtag(20, b)); end
      n_cmp++; if (bank_rready !== 2'b01 || rd_outstanding !== 5'd1) begin n_bad++; $display("FAIL order_b0_ctl%0d: got rready=%b occ=%0d want 01 1", b, bank_rready, rd_outstanding); end
    end
    step();
    bank_rvalid = '0; bank_rlast = '0;
    samp();
    n_cmp++; if (rd_outstanding !== 5'd0 || m_if.rvalid !== 1'b0) begin n_bad++; $display("FAIL order_drained: got occ=%0d mvalid=%b want 0 0", rd_outstanding, m_if.rvalid); end
  endtask

  task automatic test_overflow();
    int banks[16];
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step();
      aw_fire = 1'b1; aw_bank = BANK_W'($urandom_range(0, 1)); banks[i] = int'(aw_bank);
    end
    step();
    aw_fire = 1'b0;
    samp();
    n_cmp++; if (wr_outstanding !== 5'd16 || aw_ok !== 1'b0) begin n_bad++; $display("FAIL ovf_full: got occ=%0d aw_ok=%b want 16 0", wr_outstanding, aw_ok); end
    n_cmp++; if (err_overflow !== 1'b0 || ar_ok !== 1'b1) begin n_bad++; $display("FAIL ovf_pre: got ovf=%b ar_ok=%b want 0 1", err_overflow, ar_ok); end
    step();
    aw_fire = 1'b1; aw_bank = ~BANK_W'(banks[0]);
    step();
    aw_fire = 1'b0;
    samp();
    $display("overflow 17th fire: occ=%0d err_overflow=%b", wr_outstanding, err_overflow);
    n_cmp++; if (err_overflow !== 1'b1 || wr_outstanding !== 5'd16) begin n_bad++; $display("FAIL ovf_17th: got ovf=%b occ=%0d want 1 16", err_overflow, wr_outstanding); end
    m_if.bready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      bank_bvalid = '0; bank_bvalid[banks[i]] = 1'b1; bank_b[banks[i]*B_W +: B_W] = btag(100 + i);
      samp();
      n_cmp++; if (m_if.bvalid !== 1'b1 || m_if.b !== btag(100 + i) || wr_outstanding !== 5'(16 - i)) begin n_bad++; $display("FAIL ovf_drain%0d: got v=%b b=%0h occ=%0d want 1 %0h %0d", i, m_if.bvalid, m_if.b, wr_outstanding, btag(100 + i), 16 - i); end
    end
    step();
    bank_bvalid = '0;
    samp();
    n_cmp++; if (wr_outstanding !== 5'd0 || aw_ok !== 1'b1 || err_stray !== 1'b0) begin n_bad++; $display("FAIL ovf_end: got occ=%0d aw_ok=%b stray=%b want 0 1 0", wr_outstanding, aw_ok, err_stray); end
  endtask

  task automatic test_backpressure();
    int beat, hs, k;
    beat = 0; hs = 0; k = 0;
    do_reset();
    ar_fire = 1'b1; ar_bank = 1'b1;
    step();
    ar_fire = 1'b0;
    while (beat < 8 && k < 40) begin
      step();
      m_if.rready = (k % 2 == 0);
      bank_rvalid[1] = 1'b1; bank_rlast[1] = (beat == 7); bank_r[R_W +: R_W] = rtag(30, beat);
      samp();
      n_cmp++; if (m_if.rvalid !== 1'b1 || m_if.r !== rtag(30, beat) || m_if.rlast !== (beat == 7)) begin n_bad++; $display("FAIL bp_payload k%0d: got v=%b last=%b r=%0h want 1 %b %0h", k, m_if.rvalid, m_if.rlast, m_if.r, (beat == 7), rtag(30, beat)); end
      n_cmp++; if (rd_outstanding !== 5'd1) begin n_bad++; $display("FAIL bp_occ k%0d: got %0d want 1", k, rd_outstanding); end
      if (m_if.rvalid && m_if.rready) begin
        hs++; beat++;
      end
      k++;
    end
    step();
    bank_rvalid = '0; bank_rlast = '0; m_if.rready = 1'b0;
    samp();
    $display("backpressure handshakes=%0d occ=%0d", hs, rd_outstanding);
    n_cmp++; if (hs !== 8 || rd_outstanding !== 5'd0) begin n_bad++; $display("FAIL bp_count: got hs=%0d occ=%0d want 8 0", hs, rd_outstanding); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    ar_fire = 1'b1; ar_bank = 1'b0;
    step();
    ar_fire = 1'b0;
    step();
    bank_rvalid[0] = 1'b1; bank_rlast[0] = 1'b1; bank_r[0 +: R_W] = rtag(40, 0); m_if.rready = 1'b1;
    ar_fire = 1'b1; ar_bank = 1'b1;
    samp();
    n_cmp++; if (rd_outstanding !== 5'd1 || m_if.rvalid !== 1'b1 || bank_rready !== 2'b01) begin n_bad++; $display("FAIL same_pre: got occ=%0d v=%b rready=%b want 1 1 01", rd_outstanding, m_if.rvalid, bank_rready); end
    step();
    ar_fire = 1'b0;
    bank_rvalid = 2'b10; bank_rlast = 2'b10; bank_r[R_W +: R_W] = rtag(41, 0);
    samp();
    $display("same-cycle push/pop: occ=%0d rready=%b", rd_outstanding, bank_rready);
    n_cmp++; if (rd_outstanding !== 5'd1 || bank_rready !== 2'b10 || m_if.r !== rtag(41, 0)) begin n_bad++; $display("FAIL same_post: got occ=%0d rready=%b r=%0h want 1 10 %0h", rd_outstanding, bank_rready, m_if.r, rtag(41, 0)); end
    step();
    bank_rvalid = '0; bank_rlast = '0;
    samp();
    n_cmp++; if (rd_outstanding !== 5'd0 || err_stray !== 1'b0 || err_overflow !== 1'b0) begin n_bad++; $display("FAIL same_end: got occ=%0d stray=%b ovf=%b want 0 0 0", rd_outstanding, err_stray, err_overflow); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ar_fire = 1'b1; ar_bank = 1'b0;
    step();
    ar_bank = 1'b1;
    step();
    ar_bank = 1'b0;
    step();
    ar_fire = 1'b0;
    bank_rvalid = 2'b11; bank_rlast = 2'b00; bank_r[0 +: R_W] = rtag(50, 0); bank_r[R_W +: R_W] = rtag(51, 0);
    m_if.rready = 1'b1;
    samp();
    n_cmp++; if (rd_outstanding !== 5'd3) begin n_bad++; $display("FAIL rstmid_occ3: got %0d want 3", rd_outstanding); end
    step();
    samp();
    n_cmp++; if (err_stray !== 1'b1) begin n_bad++; $display("FAIL rstmid_stray_set: got %b want 1", err_stray); end
    step();
    reset = 1'b1;
    step();
    samp();
    $display("reset mid-burst: occ=%0d ar_ok=%b stray=%b", rd_outstanding, ar_ok, err_stray);
    n_cmp++; if (rd_outstanding !== 5'd0 || ar_ok !== 1'b1 || m_if.rvalid !== 1'b0) begin n_bad++; $display("FAIL rstmid_clear: got occ=%0d ar_ok=%b v=%b want 0 1 0", rd_outstanding, ar_ok, m_if.rvalid); end
    n_cmp++; if (err_stray !== 1'b0 || err_overflow !== 1'b0) begin n_bad++; $display("FAIL rstmid_err: got stray=%b ovf=%b want 0 0", err_stray, err_overflow); end
    step();
    reset = 1'b0; bank_rvalid = 2'b01;
    samp();
    n_cmp++; if (m_if.rvalid !== 1'b0 || bank_rready !== 2'b00) begin n_bad++; $display("FAIL rstmid_empty: got v=%b rready=%b want 0 00", m_if.rvalid, bank_rready); end
    step();
    samp();
    n_cmp++; if (err_stray !== 1'b1) begin n_bad++; $display("FAIL rstmid_inflight_stray: got %b want 1", err_stray); end
    bank_rvalid = '0;
  endtask

  // Random interleaved reads/writes. Each bank model answers only the oldest
  // transaction of its direction after a random delay; the scoreboard expects
  // beats at the DMA port in issue order, so it is latency-agnostic.
  task automatic test_random();
    txn_t           rq[$], wq[$], t;
    logic [R_W:0]   exp_r[$];
    logic [B_W-1:0] exp_b[$];
    int issued, r_beat, r_wait, b_wait, cyc, nid;
    issued = 0; r_beat = 0; r_wait = 0; b_wait = 0; cyc = 0; nid = 1000;
    do_reset();
    while ((issued < 40 || rq.size() > 0 || wq.size() > 0 || exp_r.size() > 0 || exp_b.size() > 0) && cyc < 4000) begin
      step();
      bank_rvalid = '0; bank_rlast = '0; bank_bvalid = '0;
      if (rq.size() > 0) begin
        if (r_wait > 0) r_wait--;
        else begin
          bank_rvalid[rq[0].bank] = 1'b1;
          bank_rlast[rq[0].bank]  = (r_beat == rq[0].len - 1);
          bank_r[rq[0].bank*R_W +: R_W] = rtag(rq[0].id, r_beat);
        end
      end
      if (wq.size() > 0) begin
        if (b_wait > 0) b_wait--;
        else begin
          bank_bvalid[wq[0].bank] = 1'b1;
          bank_b[wq[0].bank*B_W +: B_W] = btag(wq[0].id);
        end
      end
      ar_fire = 1'b0; aw_fire = 1'b0;
      if (issued < 40 && $urandom_range(0, 2) != 0) begin
        t.bank = int'($urandom_range(0, 1)); t.len = int'($urandom_range(1, 4)); t.id = nid;
        if ($urandom_range(0, 1) == 1) begin
          if (ar_ok) begin
            ar_fire = 1'b1; ar_bank = BANK_W'(t.bank); rq.push_back(t);
            for (int j = 0; j < t.len; j++) exp_r.push_back({(j == t.len - 1), rtag(t.id, j)});
            issued++; nid++;
          end
        end else if (aw_ok) begin
          aw_fire = 1'b1; aw_bank = BANK_W'(t.bank); wq.push_back(t);
          exp_b.push_back(btag(t.id));
          issued++; nid++;
        end
      end
      m_if.rready = ($urandom_range(0, 3) != 0);
      m_if.bready = ($urandom_range(0, 3) != 0);
      samp();
      if (m_if.rvalid && m_if.rready) begin
        n_cmp++;
        if (exp_r.size() == 0) begin n_bad++; $display("FAIL rand_r_extra: got r=%0h want no beat", m_if.r); end
        else begin
          $display("rand R beat: last=%b tag=%0h", m_if.rlast, m_if.r[23:0]);
          if ({m_if.rlast, m_if.r} !== exp_r[0]) begin n_bad++; $display("FAIL rand_r_order: got last=%b r=%0h want last=%b r=%0h", m_if.rlast, m_if.r, exp_r[0][R_W], exp_r[0][R_W-1:0]); end
          void'(exp_r.pop_front());
        end
      end
      if (m_if.bvalid && m_if.bready) begin
        n_cmp++;
        if (exp_b.size() == 0) begin n_bad++; $display("FAIL rand_b_extra: got b=%0h want no response", m_if.b); end
        else begin
          $display("rand B resp: b=%0h", m_if.b);
          if (m_if.b !== exp_b[0]) begin n_bad++; $display("FAIL rand_b_order: got b=%0h want %0h", m_if.b, exp_b[0]); end
          void'(exp_b.pop_front());
        end
      end
      if (rq.size() > 0 && bank_rvalid[rq[0].bank] && bank_rready[rq[0].bank]) begin
        if (r_beat == rq[0].len - 1) begin
          void'(rq.pop_front()); r_beat = 0; r_wait = int'($urandom_range(0, 3));
        end else r_beat++;
      end
      if (wq.size() > 0 && bank_bvalid[wq[0].bank] && bank_bready[wq[0].bank]) begin
        void'(wq.pop_front()); b_wait = int'($urandom_range(0, 3));
      end
      cyc++;
    end
    step();
    bank_rvalid = '0; bank_bvalid = '0; bank_rlast = '0; ar_fire = 1'b0; aw_fire = 1'b0;
    samp();
    n_cmp++; if (cyc >= 4000) begin n_bad++; $display("FAIL rand_timeout: got %0d cycles with r=%0d b=%0d pending want completion", cyc, exp_r.size(), exp_b.size()); end
    n_cmp++; if (err_stray !== 1'b0 || err_overflow !== 1'b0) begin n_bad++; $display("FAIL rand_err: got stray=%b ovf=%b want 0 0", err_stray, err_overflow); end
    n_cmp++; if (rd_outstanding !== 5'd0 || wr_outstanding !== 5'd0) begin n_bad++; $display("FAIL rand_occ: got rd=%0d wr=%0d want 0 0", rd_outstanding, wr_outstanding); end
  endtask

  initial begin
    test_reset();
    test_order_stray();
    test_overflow();
    test_backpressure();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dma_ddr_rsp_merge.md
# dma_ddr_rsp_merge

Response-side companion to the DMA's DDR bank steering logic. It records the target bank of every accepted AXI-MM read and write request, then returns R and B responses from the N local-memory banks to the single DMA engine port strictly in request order. Only the bank owning the oldest outstanding transaction is allowed to drive that port. It sits between the per-bank `ofs_plat_axi_mem_if` response channels and the DMA engine's memory port, replacing OR-reduction of bank responses.

## Interface
- NUM_LOCAL_MEM_BANKS, 2, number of DDR banks (≥1); BANK_W = max(1, $clog2(NUM_LOCAL_MEM_BANKS))
- R_W, 512+16, R payload width (data + id/user/resp, opaque)
- B_W, 16, B payload width (opaque)
- MAX_OUTSTANDING, 16, per-direction tracking depth (power of 2, ≥2); CNT_W = $clog2(MAX_OUTSTANDING)+1
- clk  in  1  clock; single clock domain
- reset  in  1  synchronous, active-high reset
- ar_fire  in  1  AR handshake completed this cycle (from the steering logic)
- ar_bank  in  BANK_W  bank of that AR
- ar_ok  out  1  read tracker can accept; steering logic ANDs it into arvalid/arready
- aw_fire  in  1  AW handshake completed this cycle
- aw_bank  in  BANK_W  bank of that AW
- aw_ok  out  1  write tracker can accept
- bank_rvalid  in  N  per-bank R valid
- bank_rlast  in  N  per-bank R last
- bank_r  in  N×R_W  per-bank R payload
- bank_rready  out  N  per-bank R ready
- m_rvalid / m_rlast / m_r  out  1/1/R_W  merged R to DMA
- m_rready  in  1
- bank_bvalid  in  N; bank_b  in  N×B_W; bank_bready  out  N
- m_bvalid / m_b  out  1/B_W; m_bready  in  1
- rd_outstanding, wr_outstanding  out  CNT_W  tracker occupancy
- err_overflow  out  1  sticky: fire asserted while tracker full
- err_stray  out  1  sticky: valid from a non-head bank, or any valid while tracker empty

## Operation
- Two independent order FIFOs: read and write, each of depth MAX_OUTSTANDING, storing BANK_W-wide entries.
- Push on ar_fire/aw_fire with ar_bank/aw_bank. ar_ok = (rd_outstanding < MAX_OUTSTANDING); aw_ok is defined likewise.
- A fire while full is dropped. FIFO contents are unchanged and err_overflow is set.
- R path, tracker non-empty, head bank h:
  - m_rvalid = bank_rvalid[h], m_r = bank_r[h], m_rlast = bank_rlast[h]
  - bank_rready[h] = m_rready
  - all other bank_rready = 0
- R pop: pops on an R handshake with rlast=1. Non-last beats do not pop.
- R path, tracker empty: m_rvalid = 0 and all bank_rready = 0.
- B path: same scheme. Every B handshake pops.
- Simultaneous push and pop in one cycle: occupancy is unchanged and both take effect. Push into an empty FIFO is not visible at head until the next cycle.
- err_stray is set when bank_xvalid[i] is seen for i ≠ head or with the tracker empty. The offending response is not consumed.
- Both error flags clear only on reset.
- Pointers wrap modulo MAX_OUTSTANDING. Occupancy uses the extra MSB so full and empty are distinguishable.

## Timing
- Without the macro: R/B merge is combinational with zero-cycle latency and one beat per cycle throughput.
- ar_ok/aw_ok are registered-state functions only, with no combinational path from fire.
- Reset values:
  - both FIFOs empty; rd_outstanding = wr_outstanding = 0
  - ar_ok = aw_ok = 1
  - m_rvalid = m_bvalid = 0; all bank_rready/bank_bready = 0
  - err_overflow = err_stray = 0
- Reset asserted mid-burst: all tracking is discarded on the next edge. In-flight bank responses after reset count as stray.
- AXI rule: once m_rvalid/m_bvalid is asserted, the payload holds until handshake, because head cannot change without a pop.

## Configuration
- DMA_RSP_MERGE_OUTPUT_REG_EN
  - Defined: 2-entry skid buffer on each merged output (R and B). Adds 1 cycle latency and keeps full throughput. Outputs come from flops. bank_xready is driven by skid-buffer space instead of m_xready. Pop occurs on handshake into the skid buffer. The skid buffer is empty after reset.
  - Undefined: combinational pass-through as described above.

## Test plan
- Reset, then N=2: AR to bank1 (len 4) then bank0 (len 2). Bank0 responds first → bank0 held (bank_rready[0]=0, err_stray=1). Bank1's 4 beats pass, then bank0's 2 beats. rd_outstanding goes 2→1→0.
- 16 AW fires without B → aw_ok=0, wr_outstanding=16. 17th aw_fire → err_overflow=1, occupancy stays 16.
- m_rready toggling 1010… during an 8-beat burst → exactly 8 handshakes. Payload is stable while m_rvalid=1 and m_rready=0. Pop only on the beat with rlast.
- Same-cycle ar_fire and final rlast handshake with occupancy 1 → occupancy stays 1. The new bank becomes head next cycle.
- 40 interleaved random reads/writes across banks with random bank latency → responses in request order, zero errors, with and without DMA_RSP_MERGE_OUTPUT_REG_EN (1-cycle added latency when defined).
- Reset asserted mid-burst with 3 outstanding → next cycle occupancy 0, ar_ok=1, m_rvalid=0, errors cleared.
